// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-memory handshake, branch resolve and MEM/WB register
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        mWreg,
  input  logic        mReg2reg,
  input  logic        mWmem,
  input  logic [5:0]  mOp,
  input  logic        mZ,
  input  logic [31:0] mPc,
  input  logic [31:0] mR,
  input  logic [31:0] mS,
  input  logic [4:0]  mRd,
  output logic        Stall,
  output logic        Branch,
  output logic [31:0] BranchPc,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [31:0] DWdata,
  input  logic        DAck,
  input  logic [31:0] DRdata,
  output logic        wWreg,
  output logic        wReg2reg,
  output logic [4:0]  wRd,
  output logic [31:0] wR,
  output logic [31:0] wD,
  output logic        Err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nextState;
  logic [7:0] waitCnt;
  logic abort;
  logic isLoad, isStore, memOp, timeout;
  assign isLoad = mOp == 6'b100011;
  assign isStore = mWmem;
  assign memOp = isLoad | isStore;
  assign timeout = state == ACCESS && !DAck && waitCnt == 8'(MAX_WAIT - 1);
  assign Branch = (mOp == 6'b000100 && mZ) || (mOp == 6'b000101 && !mZ);
  assign BranchPc = mPc;
  // next state and handshake outputs; the request is held stable for the whole ACCESS phase
  always_comb begin
    nextState = state;
    Stall = 1'b0;
    DReq = 1'b0;
    DWe = 1'b0;
    DAddr = 32'h0;
    DWdata = 32'h0;
    nextState = state == IDLE ? (memOp ? ACCESS : IDLE) :
                state == ACCESS ? ((DAck || timeout) ? DONE : ACCESS) : IDLE;
    Stall = (state == IDLE && memOp) || state == ACCESS;
    DReq = state == ACCESS;
    DWe = DReq && isStore;
    DAddr = DReq ? mR : 32'h0;
    DWdata = DReq ? mS : 32'h0;
  end
  // state, wait counter, abort marker and sticky timeout flag
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
      waitCnt <= 8'h0;
      abort <= 1'b0;
      Err <= 1'b0;
    end else begin
      state <= nextState;
      waitCnt <= (state == ACCESS && !DAck && !timeout) ? waitCnt + 8'h1 : 8'h0;
      abort <= timeout ? 1'b1 : (state == DONE ? 1'b0 : abort);
      Err <= Err | timeout;
    end
  end
  // MEM/WB register: bubble while a memop waits, retire on DONE, capture load data on ack
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      wWreg <= 1'b0;
      wReg2reg <= 1'b0;
      wRd <= 5'h0;
      wR <= 32'h0;
      wD <= 32'h0;
    end else if (state == IDLE && memOp) begin
      wWreg <= 1'b0;
    end else if (state == IDLE || state == DONE) begin
      wWreg <= mWreg && !(state == DONE && abort);
      wReg2reg <= mReg2reg;
      wRd <= mRd;
      wR <= mR;
    end else if (DAck && isLoad) begin
      wD <= DRdata;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a behavioural model
module tb_mem_stage;
  localparam int MW = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  logic Clk = 0, Clr = 1;
  logic mWreg = 0, mReg2reg = 0, mWmem = 0, mZ = 0, DAck = 0;
  logic [5:0] mOp = 0;
  logic [31:0] mPc = 0, mR = 0, mS = 0, DRdata = 0;
  logic [4:0] mRd = 0;
  logic Stall, Branch, DReq, DWe, wWreg, wReg2reg, Err;
  logic [31:0] BranchPc, DAddr, DWdata, wR, wD;
  logic [4:0] wRd;
  logic eStall = 0, eBranch = 0, eDReq = 0, eDWe = 0, eWreg = 0, eR2r = 0, eErr = 0;
  logic [31:0] eBranchPc = 0, eDAddr = 0, eDWdata = 0, eR = 0, eD = 0;
  logic [4:0] eRd = 0;
  logic chkOn = 0;
  int nChk = 0, nFail = 0, run = 0, lastRun = 0;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .Clk(Clk), .Clr(Clr), .mWreg(mWreg), .mReg2reg(mReg2reg), .mWmem(mWmem), .mOp(mOp),
    .mZ(mZ), .mPc(mPc), .mR(mR), .mS(mS), .mRd(mRd), .Stall(Stall), .Branch(Branch),
    .BranchPc(BranchPc), .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DAck(DAck), .DRdata(DRdata), .wWreg(wWreg), .wReg2reg(wReg2reg), .wRd(wRd),
    .wR(wR), .wD(wD), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nChk++;
    if (a !== e) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Clr) run = 0;
    else if (Stall) run++;
    else if (run != 0) begin
      lastRun = run;
      run = 0;
    end
    if (chkOn) begin
      chk("Stall", 32'(Stall), 32'(eStall));
      chk("Branch", 32'(Branch), 32'(eBranch));
      chk("BranchPc", BranchPc, eBranchPc);
      chk("DReq", 32'(DReq), 32'(eDReq));
      chk("DWe", 32'(DWe), 32'(eDWe));
      chk("DWdata", DWdata, eDWdata);
      if (eDReq) chk("DAddr", DAddr, eDAddr);
      chk("wWreg", 32'(wWreg), 32'(eWreg));
      chk("wReg2reg", 32'(wReg2reg), 32'(eR2r));
      chk("wRd", 32'(wRd), 32'(eRd));
      chk("wR", wR, eR);
      chk("wD", wD, eD);
      chk("Err", 32'(Err), 32'(eErr));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleOut(input logic noise);
    eStall = 0; eDReq = 0; eDWe = 0; eDWdata = 0;
    DAck = noise ? 1'($urandom) : 1'b0;
    DRdata = $urandom;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic wreg, input logic r2r, input logic wmem,
                          input logic z, input logic [31:0] pc, input logic [31:0] r,
                          input logic [31:0] s, input logic [4:0] rd, input int ackAt,
                          input logic [31:0] rdata, input logic noise);
    logic acked;
    int n;
    mOp = op; mWreg = wreg; mReg2reg = r2r; mWmem = wmem; mZ = z; mPc = pc; mR = r; mS = s; mRd = rd;
    eBranch = (op == BEQ && z) || (op == BNE && !z);
    eBranchPc = pc;
    if (!(op == LW || wmem)) begin
      idleOut(noise);
      step();
      eWreg = wreg; eR2r = r2r; eRd = rd; eR = r;
    end else begin
      idleOut(noise);
      eStall = 1;
      step();
      eWreg = 0;
      acked = ackAt >= 1 && ackAt <= MW;
      n = acked ? ackAt : MW;
      for (int i = 1; i <= n; i++) begin
        eStall = 1; eDReq = 1; eDWe = wmem; eDAddr = r; eDWdata = s;
        DAck = i == ackAt;
        DRdata = (i == ackAt) ? rdata : $urandom;
        step();
      end
      if (acked && op == LW) eD = rdata;
      if (!acked) eErr = 1;
      idleOut(noise);
      step();
      eWreg = wreg && acked; eR2r = r2r; eRd = rd; eR = r;
    end
    DAck = 0;
  endtask

  task automatic brLit(input logic [5:0] op, input logic z, input logic [31:0] pc, input logic expB);
    mOp = op; mZ = z; mPc = pc; mWreg = 0; mReg2reg = 0; mWmem = 0; mR = 0; mRd = 0; mS = 0;
    eBranch = expB; eBranchPc = pc;
    idleOut(0);
    #1;
    chk("branch literal", 32'(Branch), 32'(expB));
    chk("branchpc literal", BranchPc, pc);
    step();
    eWreg = 0; eR2r = 0; eRd = 0; eR = 0;
  endtask

  initial begin
    logic [5:0] op;
    int kind;
    repeat (2) @(posedge Clk);
    #1;
    Clr = 0;
    chk("reset wWreg", 32'(wWreg), 0);
    chk("reset wR", wR, 0);
    chk("reset wD", wD, 0);
    chk("reset Err", 32'(Err), 0);
    chk("reset DReq", 32'(DReq), 0);
    chkOn = 1;
    runInstr(6'd0, 1, 0, 0, 0, 0, 32'h1234, 0, 5'd5, 0, 0, 0);
    chk("alu wWreg", 32'(wWreg), 1);
    chk("alu wR", wR, 32'h1234);
    chk("alu wRd", 32'(wRd), 5);
    runInstr(LW, 1, 1, 0, 0, 0, 32'h40, 0, 5'd7, 3, 32'hDEADBEEF, 1);
    chk("load stall cycles", lastRun, 4);
    chk("load wD", wD, 32'hDEADBEEF);
    chk("load wWreg", 32'(wWreg), 1);
    runInstr(SW, 0, 0, 1, 0, 0, 32'h80, 32'h55AA, 5'd0, 1, 0, 0);
    chk("store stall cycles", lastRun, 2);
    chk("store wWreg", 32'(wWreg), 0);
    chk("store wD held", wD, 32'hDEADBEEF);
    runInstr(LW, 1, 1, 0, 0, 0, 32'h60, 0, 5'd9, MW, 32'hCAFE0001, 0);
    chk("late ack stall cycles", lastRun, MW + 1);
    chk("late ack no Err", 32'(Err), 0);
    chk("late ack wD", wD, 32'hCAFE0001);
    runInstr(LW, 1, 1, 0, 0, 0, 32'h44, 0, 5'd3, 0, 0, 0);
    chk("timeout stall cycles", lastRun, MW + 1);
    chk("timeout Err", 32'(Err), 1);
    chk("timeout wWreg", 32'(wWreg), 0);
    runInstr(6'd0, 1, 0, 0, 0, 0, 32'h77, 0, 5'd2, 0, 0, 0);
    chk("post-timeout alu wWreg", 32'(wWreg), 1);
    chk("Err sticky", 32'(Err), 1);
    runInstr(LW, 1, 0, 0, 0, 0, 32'h48, 0, 5'd4, 1, 32'h0BADF00D, 0);
    runInstr(LW, 1, 0, 0, 0, 0, 32'h4C, 0, 5'd6, 2, 32'h12345678, 0);
    chk("back-to-back wD", wD, 32'h12345678);
    brLit(BEQ, 1, 32'h100, 1);
    brLit(BNE, 1, 32'h104, 0);
    brLit(BNE, 0, 32'h108, 1);
    brLit(BEQ, 0, 32'h10C, 0);
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 5);
      op = 6'($urandom);
      if (op == LW) op = 6'd0;
      case (kind)
        0, 1: runInstr(op, 1'($urandom), 1'($urandom), 0, 1'($urandom), $urandom, $urandom,
                       $urandom, 5'($urandom), 0, 0, 1'($urandom));
        2: runInstr($urandom_range(0, 1) ? BEQ : BNE, 0, 0, 0, 1'($urandom), $urandom, $urandom,
                    $urandom, 5'($urandom), 0, 0, 1'($urandom));
        3, 4: runInstr(LW, 1'($urandom), 1'($urandom), 0, 1'($urandom), $urandom, $urandom,
                       $urandom, 5'($urandom), $urandom_range(1, MW + 2), $urandom, 1'($urandom));
        default: runInstr(op, 1'($urandom), 1'($urandom), 1, 1'($urandom), $urandom, $urandom,
                          $urandom, 5'($urandom), $urandom_range(1, MW + 2), $urandom, 1'($urandom));
      endcase
    end
    mOp = LW; mWmem = 0; mR = 32'h90; mWreg = 1;
    eBranch = 0; eBranchPc = mPc;
    idleOut(0);
    eStall = 1;
    step();
    eWreg = 0;
    eDReq = 1; eDWe = 0; eDAddr = 32'h90; eDWdata = mS;
    step();
    chk("DReq before reset", 32'(DReq), 1);
    #2;
    chkOn = 0;
    Clr = 1;
    #1;
    chk("reset DReq async", 32'(DReq), 0);
    chk("reset wWreg async", 32'(wWreg), 0);
    chk("reset wReg2reg async", 32'(wReg2reg), 0);
    chk("reset wRd async", 32'(wRd), 0);
    chk("reset wR async", wR, 0);
    chk("reset wD async", wD, 0);
    chk("reset Err async", 32'(Err), 0);
    mOp = 0; mWreg = 0; mReg2reg = 0; mRd = 0; mR = 0;
    @(posedge Clk);
    #3;
    Clr = 0;
    eWreg = 0; eR2r = 0; eRd = 0; eR = 0; eD = 0; eErr = 0;
    idleOut(0);
    step();
    chkOn = 1;
    runInstr(6'd0, 1, 1, 0, 0, 0, 32'hABCD, 0, 5'd11, 0, 0, 0);
    chk("after reset alu wR", wR, 32'hABCD);
    chk("after reset stall idle", 32'(Stall), 0);
    runInstr(SW, 0, 0, 1, 0, 0, 32'h84, 32'h1111, 5'd0, 2, 0, 0);
    chk("after reset store stall cycles", lastRun, 3);
    @(negedge Clk);
    chkOn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage consumer of the EX/MEM pipeline register in the simple 32-bit pipelined CPU. It decodes the EX/MEM outputs (`mWreg`, `mReg2reg`, `mWmem`, `mOp`, `mPc`, `mZ`, `mR`, `mS`, `mRd`) and performs data-memory loads and stores over a req/ack handshake. It stalls the upstream pipeline while an access is in flight, resolves conditional branches, and contains the MEM/WB register that feeds write-back.

## Interface
Parameters:
- `MAX_WAIT`, 15: maximum ACCESS cycles without `DAck` before abort. Legal range is 1..255.

Ports:
- `Clk` in 1: the single clock; rising edge.
- `Clr` in 1: reset, asynchronous and active-high.
- `mWreg`, `mReg2reg`, `mWmem` in 1 each: control bits from EX/MEM.
- `mOp` in 6: opcode from EX/MEM.
- `mZ` in 1: ALU zero flag.
- `mPc` in 32: branch target computed in EX.
- `mR` in 32: ALU result, used as the memory address.
- `mS` in 32: store data.
- `mRd` in 5: destination register.
- `Stall` out 1: drives the `En` of EX/MEM and all earlier pipeline registers low when 1.
- `Branch` out 1: branch taken.
- `BranchPc` out 32: redirect target.
- `DReq` out 1, `DWe` out 1, `DAddr` out 32, `DWdata` out 32: data-memory request.
- `DAck` in 1, `DRdata` in 32: data-memory response.
- `wWreg`, `wReg2reg` out 1 each; `wRd` out 5; `wR` out 32; `wD` out 32: MEM/WB register outputs.
- `Err` out 1: sticky memory-timeout flag.

## Operation
- Decode:
  - load = (`mOp` == 6'b100011)
  - store = `mWmem`
  - memop = load | store
- Branch (combinational):
  - `Branch` = (`mOp` == 6'b000100 & `mZ`) | (`mOp` == 6'b000101 & ~`mZ`)
  - `BranchPc` = `mPc`
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If memop: `Stall` = 1, the MEM/WB register loads a bubble (`wWreg` <= 0, other fields hold), and the next state is ACCESS.
  - Otherwise: `Stall` = 0 and the MEM/WB register loads `mWreg`, `mReg2reg`, `mRd`, `mR`; `wD` holds.
- ACCESS:
  - Outputs: `Stall` = 1, `DReq` = 1, `DWe` = store, `DAddr` = `mR`, `DWdata` = `mS`. These stay stable until ack or abort.
  - The wait counter increments each cycle.
  - On `DAck` = 1: `wD` <= `DRdata` for loads (`wD` holds for stores), the counter is cleared, and the next state is DONE.
  - If the counter reaches `MAX_WAIT`-1 with no ack: `Err` <= 1, an abort flag is set, and the next state is DONE.
- DONE:
  - `Stall` = 0, `DReq` = 0.
  - MEM/WB loads the instruction. `wWreg` = `mWreg` & ~abort.
  - Abort flag cleared; next state is IDLE.
- `DAck` and `DRdata` are ignored outside ACCESS.
- `DReq` is 0 in IDLE and DONE. `DWe` and `DWdata` are don't-care when `DReq` = 0 and are driven 0.
- `Err` is cleared only by `Clr`.

## Timing
- Reset (`Clr` = 1, async):
  - state IDLE, counter 0, abort 0, `Err` 0
  - `wWreg` = `wReg2reg` = 0, `wRd` = 0, `wR` = `wD` = 0
  - `DReq` drops to 0 immediately, including mid-access. There is no retry after reset.
- Non-memory instruction: 1 cycle in MEM. It appears on `w*` after the next edge.
- Memory instruction with `DAck` in the k-th ACCESS cycle (k ≥ 1):
  - `Stall` is high for 1+k cycles.
  - `w*` is valid k+2 edges after the instruction enters MEM.
  - Minimum is 2 stall cycles.
- Timeout: `Stall` is high for 1+`MAX_WAIT` cycles. `Err` rises on the edge leaving ACCESS.
- `DAck` in the same cycle as counter = `MAX_WAIT`-1: the ack wins and there is no error.
- `Branch` is combinational from the EX/MEM outputs and is valid in the cycle the instruction sits in MEM. Branches are never memops, so `Branch` never coincides with `Stall`.
- Back-to-back memops: DONE → IDLE with the new memop re-enters ACCESS. There is one non-stall cycle (DONE) between them.

## Test plan
- Reset mid-ACCESS with `DReq` = 1, then assert `Clr` → `DReq` = 0 within the same cycle, all `w*` = 0, `Err` = 0, state IDLE.
- ALU op (`mOp` = 0, `mWreg` = 1, `mR` = 0x1234, `mRd` = 5) → no stall; after 1 edge `wWreg` = 1, `wR` = 0x1234, `wRd` = 5, `DReq` never 1.
- Load (`mOp` = 6'b100011, `mR` = 0x40), memory acks on the 3rd ACCESS cycle with `DRdata` = 0xDEADBEEF:
  - `DAddr` = 0x40 and `DWe` = 0 while `DReq` = 1
  - `Stall` high for 4 cycles
  - then `wD` = 0xDEADBEEF, `wWreg` = 1
- Store (`mWmem` = 1, `mR` = 0x80, `mS` = 0x55AA) with immediate ack → `DWe` = 1, `DWdata` = 0x55AA, `Stall` high for 2 cycles, `wWreg` = 0.
- Timeout with `MAX_WAIT` = 4 and `DAck` held 0:
  - `Stall` high for 5 cycles, `Err` = 1 sticky
  - the load retires with `wWreg` = 0
  - a following ALU op proceeds normally while `Err` stays 1
- Branches:
  - beq (`mOp` = 6'b000100) with `mZ` = 1, `mPc` = 0x100 → `Branch` = 1, `BranchPc` = 0x100
  - bne with `mZ` = 1 → `Branch` = 0
  - bne with `mZ` = 0 → `Branch` = 1
